// File: rtl/keypad_matrix_scan_pkg.sv
// keypad_matrix_scan shared definitions
// Matrix geometry, column drive patterns and key helpers
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 16;

    // Active-low column drive, indexed by column number
    localparam logic [3:0][3:0] COL_DRV = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    // Key indices as seen by the onehot decoder (row*4 + col)
    localparam logic [3:0] KEY_ENTER = 4'd0;
    localparam logic [3:0] KEY_CLEAR = 4'd8;

    function automatic logic [4:0] f_popcount(input logic [KEY_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < KEY_W; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] f_encode(input logic [KEY_W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_matrix_scan_if.sv
// keypad_matrix_scan frame / key result bundle
// Scanner side is master, frame filter side is slave
interface keypad_matrix_scan_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] frame;
    logic             frame_done;
    logic [KEY_W-1:0] onehot;
    logic [3:0]       key_code;
    logic             key_valid;
    logic             multi_key;

    modport master (
        output frame, frame_done,
        input  onehot, key_code, key_valid, multi_key
    );

    modport slave (
        input  frame, frame_done,
        output onehot, key_code, key_valid, multi_key
    );
endinterface

// File: rtl/keypad_matrix_scan_filter.sv
// kp_frame_filter: debounce, ghost rejection, key encode
// Accepts a frame once it repeats DEBOUNCE_SCANS times
module kp_frame_filter
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic                 clk,
    input logic                 RSTn,
    keypad_matrix_scan_if.slave bus
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic [KEY_W-1:0] r_prev;
    logic [3:0]       r_stable;
    logic [KEY_W-1:0] r_onehot;
    logic [3:0]       r_code;
    logic             r_valid;
    logic             r_multi;

    logic             w_same;
    logic [3:0]       w_stable_next;
    logic             w_accept;
    logic [4:0]       w_pop;

    // Next stable count and acceptance decision for this frame
    always_comb begin
        w_same        = (bus.frame == r_prev);
        w_stable_next = 4'd1;
        if (w_same) begin
            w_stable_next = (r_stable == DEB) ? DEB : r_stable + 4'd1;
        end
        w_accept = bus.frame_done && (w_stable_next == DEB);
        w_pop    = f_popcount(bus.frame);
    end

    // Debounce state and registered key outputs
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_prev   <= '0;
            r_stable <= '0;
            r_onehot <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_multi  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.frame_done) begin
                r_stable <= w_stable_next;
                if (!w_same) r_prev <= bus.frame;
            end
            if (w_accept) begin
                unique case (1'b1)
                    (w_pop == 5'd0): begin
                        r_onehot <= '0;
                        r_multi  <= 1'b0;
                    end
                    (w_pop == 5'd1): begin
                        r_onehot <= bus.frame;
                        r_code   <= f_encode(bus.frame);
                        r_multi  <= 1'b0;
                        r_valid  <= (bus.frame != r_onehot);
                    end
                    (w_pop > 5'd1): begin
                        r_onehot <= '0;
                        r_multi  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.onehot    = r_onehot;
    assign bus.key_code  = r_code;
    assign bus.key_valid = r_valid;
    assign bus.multi_key = r_multi;

endmodule

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: 4x4 keypad column scanner
// Synchronizes rows, rotates columns, assembles frames
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] onehot,
    output logic [3:0]       key_code,
    output logic             key_valid,
    output logic             multi_key
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_col;
    logic [3:0]       r_col_out;
    logic [KEY_W-1:0] r_frame;

    logic             w_slot_end;
    logic [KEY_W-1:0] w_frame_next;

    keypad_matrix_scan_if u_bus ();

    assign w_slot_end = (r_cnt == CNT_MAX);

    // Frame with the current column's row bits merged in
    always_comb begin
        w_frame_next = r_frame;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_frame_next[{2'(r), r_col}] = ~r_sync2[r];
        end
    end

    // Two-stage synchronizer for the asynchronous rows
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= row_in;
            r_sync2 <= r_sync1;
        end
    end

    // Slot counter, column rotation and frame capture
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt     <= '0;
            r_col     <= '0;
            r_col_out <= COL_DRV[0];
            r_frame   <= '0;
        end else if (w_slot_end) begin
            r_cnt     <= '0;
            r_col     <= r_col + 2'd1;
            r_col_out <= COL_DRV[r_col + 2'd1];
            r_frame   <= w_frame_next;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign u_bus.frame      = w_frame_next;
    assign u_bus.frame_done = w_slot_end && (r_col == 2'd3);

    kp_frame_filter #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_filter (
        .clk (clk),
        .RSTn(RSTn),
        .bus (u_bus.slave)
    );

    assign col_out   = r_col_out;
    assign onehot    = u_bus.onehot;
    assign key_code  = u_bus.key_code;
    assign key_valid = u_bus.key_valid;
    assign multi_key = u_bus.multi_key;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan: directed checks with a keypad model
// SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle frame)
module tb_keypad_matrix_scan;
    import keypad_pkg::*;

    logic        clk;
    logic        RSTn;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] pressed;

    int checks   = 0;
    int failures = 0;
    int n_pulse  = 0;

    keypad_matrix_scan_if u_mon ();

    assign u_mon.frame      = '0;
    assign u_mon.frame_done = 1'b0;

    keypad_matrix_scan #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .RSTn     (RSTn),
        .row_in   (row_in),
        .col_out  (col_out),
        .onehot   (u_mon.onehot),
        .key_code (u_mon.key_code),
        .key_valid(u_mon.key_valid),
        .multi_key(u_mon.multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to a low column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (u_mon.key_valid === 1'b1) n_pulse++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_onehot(input string tag, input logic [15:0] exp,
                               input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (u_mon.onehot === exp) break;
        end
        chk(tag, {16'd0, u_mon.onehot}, {16'd0, exp});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_col"}, {28'd0, col_out}, 32'h0000_000E);
        chk({tag, "_onehot"}, {16'd0, u_mon.onehot}, 32'd0);
        chk({tag, "_code"}, {28'd0, u_mon.key_code}, 32'd0);
        chk({tag, "_valid"}, {31'd0, u_mon.key_valid}, 32'd0);
        chk({tag, "_multi"}, {31'd0, u_mon.multi_key}, 32'd0);
    endtask

    initial begin
        int p0;
        int bad;
        logic [3:0] exp_col;

        RSTn    = 1'b0;
        pressed = '0;
        #12;
        chk_reset_outs("rst");

        // Idle scan: column rotates every 4 cycles
        @(negedge clk);
        RSTn = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_col = COL_DRV[(k / 4) % 4];
            chk("col_seq", {28'd0, col_out}, {28'd0, exp_col});
            @(negedge clk);
        end
        repeat (40) @(negedge clk);
        chk("idle_onehot", {16'd0, u_mon.onehot}, 32'd0);
        chk("idle_pulses", n_pulse, 0);

        // Single key row1/col2, then release
        p0 = n_pulse;
        pressed = 16'h0040;
        wait_onehot("k6_onehot", 16'h0040, 67);
        chk("k6_code", {28'd0, u_mon.key_code}, 32'd6);
        repeat (20) @(negedge clk);
        chk("k6_pulses", n_pulse, p0 + 1);
        pressed = '0;
        wait_onehot("k6_release", 16'h0000, 67);
        repeat (20) @(negedge clk);
        chk("k6_rel_pulses", n_pulse, p0 + 1);
        chk("k6_code_hold", {28'd0, u_mon.key_code}, 32'd6);

        // Bouncy press on row0/col0
        p0 = n_pulse;
        pressed = 16'h0001;
        repeat (2) @(negedge clk);
        pressed = 16'h0000;
        repeat (2) @(negedge clk);
        pressed = 16'h0001;
        repeat (2) @(negedge clk);
        pressed = 16'h0000;
        repeat (2) @(negedge clk);
        pressed = 16'h0001;
        wait_onehot("bnc_onehot", 16'h0001, 80);
        repeat (20) @(negedge clk);
        chk("bnc_pulses", n_pulse, p0 + 1);

        // 12-cycle glitch on row2/col3 must not reach onehot
        bad = 0;
        pressed = 16'h0801;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_mon.onehot !== 16'h0001) bad++;
        end
        pressed = 16'h0001;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (u_mon.onehot !== 16'h0001) bad++;
        end
        chk("glitch_bad_cycles", bad, 0);
        chk("glitch_multi", {31'd0, u_mon.multi_key}, 32'd0);
        chk("glitch_pulses", n_pulse, p0 + 1);
        pressed = '0;
        wait_onehot("bnc_release", 16'h0000, 70);

        // Ghost: row0/col1 + row3/col1, then release row3
        p0 = n_pulse;
        pressed = 16'h2002;
        repeat (70) @(negedge clk);
        chk("ghost_onehot", {16'd0, u_mon.onehot}, 32'd0);
        chk("ghost_multi", {31'd0, u_mon.multi_key}, 32'd1);
        chk("ghost_pulses", n_pulse, p0);
        pressed = 16'h0002;
        wait_onehot("ghost_single", 16'h0002, 70);
        chk("ghost_multi_clr", {31'd0, u_mon.multi_key}, 32'd0);
        chk("ghost_code", {28'd0, u_mon.key_code}, 32'd1);
        repeat (20) @(negedge clk);
        chk("ghost_pulses2", n_pulse, p0 + 1);
        pressed = '0;
        wait_onehot("ghost_release", 16'h0000, 70);

        // Direct key-to-key move: 8 then 12
        p0 = n_pulse;
        pressed = 16'h0100;
        wait_onehot("mv_k8", 16'h0100, 70);
        chk("mv_code8", {28'd0, u_mon.key_code}, {28'd0, KEY_CLEAR});
        pressed = 16'h1000;
        wait_onehot("mv_k12", 16'h1000, 70);
        chk("mv_code12", {28'd0, u_mon.key_code}, 32'd12);
        repeat (20) @(negedge clk);
        chk("mv_pulses", n_pulse, p0 + 2);

        // Asynchronous reset while key 12 is accepted and held
        @(negedge clk);
        #2;
        RSTn = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk);
        RSTn = 1'b1;
        repeat (47) @(negedge clk);
        chk("rerun_early", {16'd0, u_mon.onehot}, 32'd0);
        @(negedge clk);
        chk("rerun_onehot", {16'd0, u_mon.onehot}, 32'h0000_1000);
        chk("rerun_valid", {31'd0, u_mon.key_valid}, 32'd1);
        chk("rerun_code", {28'd0, u_mon.key_code}, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scan.md
Name: keypad_matrix_scan

Overview:
- Scans a 4x4 matrix keypad and produces the debounced 16-bit one-hot key code consumed by the keypad-to-BCD password/display logic.
- Drives one column low at a time and samples the active-low rows.
- Assembles a 16-bit frame per full scan and accepts a frame only after it has repeated unchanged for DEBOUNCE_SCANS scans.
- Sits between the board keypad pins and the onehot decoder.

Parameters:
- SCAN_DIV, 50000, clk cycles per column slot (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical frames required before acceptance; range 1..15.

Ports:
- clk  in  1  system clock, 50 MHz
- RSTn  in  1  asynchronous, active-low reset
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_out  out  4  column drive, active-low, exactly one bit low at any time
- onehot  out  16  debounced key, bit index = row*4 + col; 16'h0000 = no key
- key_code  out  4  binary index of the currently held key; holds its last value when no key is held
- key_valid  out  1  one-cycle pulse when onehot changes to a new nonzero value
- multi_key  out  1  high while the accepted frame has more than one key pressed

Behaviour:
- Reset (RSTn low, asynchronous) clears the block immediately:
  - col_out=4'b1110, onehot=0, key_code=0, key_valid=0, multi_key=0.
  - col index=0, slot counter=0, frame and previous-frame registers=0, stable count=0.
- Reset asserted mid-scan or mid-debounce discards all partial state. No output glitches after release.
- row_in passes through a 2-FF synchronizer before use.
- Slot counter runs 0..SCAN_DIV-1.
- At count SCAN_DIV-1:
  - Latch ~row_sync into frame bits {row*4+col} for the current column.
  - Advance col (0,1,2,3,0), so col_out rotates 1110, 1101, 1011, 0111.
- Row settling time is SCAN_DIV-1 cycles, which covers the synchronizer latency.
- Frame complete: on the cycle col 3 is sampled. The new frame value includes the col-3 bits.
- Debounce, evaluated on frame complete:
  - New frame == previous frame: stable count increments, saturating at DEBOUNCE_SCANS.
  - New frame != previous frame: stable count = 1, and previous frame is updated.
- Acceptance happens on the frame-complete cycle on which stable count reaches DEBOUNCE_SCANS (registered update next cycle):
  - Popcount 0: onehot=0, multi_key=0; key_code holds.
  - Popcount 1: onehot=frame, key_code=index, multi_key=0. key_valid pulses if the new onehot differs from the old onehot.
  - Popcount >1: onehot=0, multi_key=1, no key_valid (ghost rejection). The output stays strictly one-hot or zero.
- While saturated, repeated identical frames produce no further key_valid pulses. A held key yields exactly one pulse.
- A direct change between two single keys with no release between them gives a new onehot and one key_valid pulse.
- Latency: a press stable before a frame start appears on onehot within (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- A bounce shorter than one frame that reverts restarts the count; onehot is unaffected.

Decomposition:
- Package keypad_pkg holds:
  - NUM_ROWS=4, NUM_COLS=4, KEY_W=16.
  - Column drive patterns COL_DRV[0..3].
  - Named key-index constants matching the decoder's mapping, e.g. KEY_ENTER=0, KEY_CLEAR=8.
- One sub-module, kp_frame_filter, holds the debounce counter, previous-frame compare, popcount/ghost check, onehot-to-index encode, and key_valid generation.
- The top level holds the synchronizer, slot counter and column rotation.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle frame.
- Reset, no keys held -> col_out sequence 1110, 1101, 1011, 0111 repeats with a 4-cycle period. onehot=0, key_valid never asserts.
- Hold row1/col2 steady -> onehot=16'h0040 and key_code=6 no later than 67 cycles after press, with exactly one key_valid pulse. Release -> onehot=0 after 3 stable frames, no pulse.
- Press row0/col0 with 3 bounces within the first 10 cycles -> still a single key_valid, onehot=16'h0001. A 12-cycle glitch on row2/col3 never reaches onehot.
- Hold row0/col1 and row3/col1 together -> onehot=0, multi_key=1, no key_valid. Release row3 -> onehot=16'h0002, multi_key=0, one pulse.
- Move directly from key 16'h0100 to key 16'h1000 -> two key_valid pulses total, and key_code steps 8 then 12.
- Assert RSTn low mid-frame while a key is accepted -> all outputs return to reset values in the same cycle. After release, the key is re-accepted only after 3 fresh frames.
